// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the time-set controller: FSM states,
// editing codes, BCD field widths and the wrap limits of hours and minutes.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  localparam logic [1:0] EDIT_NONE = 2'b00;
  localparam logic [1:0] EDIT_HOUR = 2'b01;
  localparam logic [1:0] EDIT_MIN  = 2'b10;

  localparam int HT_W = 2;
  localparam int HU_W = 4;
  localparam int MT_W = 3;
  localparam int MU_W = 4;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  typedef struct packed {
    logic [HT_W-1:0] ten;
    logic [HU_W-1:0] unit;
  } hour_t;

  typedef struct packed {
    logic [MT_W-1:0] ten;
    logic [MU_W-1:0] unit;
  } min_t;

  // Anything at or past the limit, or not valid BCD, wraps straight to 00.
  function automatic hour_t hour_inc(input hour_t h);
    hour_t r;
    int    v;
    v = int'(h.ten) * 10 + int'(h.unit);
    r = '0;
    if (h.unit <= 4'd9 && v < HOUR_MAX) begin
      if (h.unit == 4'd9) begin
        r.ten = h.ten + 2'd1;
      end else begin
        r.ten  = h.ten;
        r.unit = h.unit + 4'd1;
      end
    end
    return r;
  endfunction

  function automatic min_t min_inc(input min_t m);
    min_t r;
    int   v;
    v = int'(m.ten) * 10 + int'(m.unit);
    r = '0;
    if (m.unit <= 4'd9 && v < MIN_MAX) begin
      if (m.unit == 4'd9) begin
        r.ten = m.ten + 3'd1;
      end else begin
        r.ten  = m.ten;
        r.unit = m.unit + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..DIV-1 while enabled and flags the last
// count; held at zero while disabled or cleared.
module tick_prescaler #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day set controller: 1 Hz enable, mode/inc edit FSM, blink phase and
// parallel load. Define SET_TIMEOUT_EN to abort idle edits after TIMEOUT_TICKS.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_DIV       = 50000000,
  parameter int BLINK_DIV     = 25000000,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_mode,
  input  logic            btn_inc,
  input  logic [HT_W-1:0] cur_hour_ten,
  input  logic [HU_W-1:0] cur_hour_unit,
  input  logic [MT_W-1:0] cur_min_ten,
  input  logic [MU_W-1:0] cur_min_unit,
  output logic            tick_en,
  output logic            load,
  output logic [HT_W-1:0] ld_hour_ten,
  output logic [HU_W-1:0] ld_hour_unit,
  output logic [MT_W-1:0] ld_min_ten,
  output logic [MU_W-1:0] ld_min_unit,
  output logic            ld_sec_clr,
  output logic [1:0]      editing,
  output logic            blink
);

  if (CLK_DIV < 2 || BLINK_DIV < 1 || TIMEOUT_TICKS < 1) begin : g_bad_param
    $error("clock_set_ctrl: parameter out of range");
  end

  state_t state;
  hour_t  sh_hour;
  min_t   sh_min;
  logic   run_en;
  logic   in_set;
  logic   any_btn;
  logic   blink_tick;
  logic   timeout;

  assign run_en  = (state == RUN);
  assign in_set  = (state == SET_HOUR) || (state == SET_MIN);
  assign any_btn = btn_mode || btn_inc;

  // Leaving RUN clears the count so the SET states and COMMIT see it at zero.
  tick_prescaler #(.DIV(CLK_DIV)) u_sec_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (run_en),
    .clear  (btn_mode),
    .tick   (tick_en)
  );

  tick_prescaler #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (in_set),
    .clear  (any_btn),
    .tick   (blink_tick)
  );

`ifdef SET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  logic            to_tick;
  logic [TO_W-1:0] to_cnt;

  tick_prescaler #(.DIV(CLK_DIV)) u_timeout_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (in_set),
    .clear  (any_btn),
    .tick   (to_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (!in_set || any_btn) begin
      to_cnt <= '0;
    end else if (to_tick) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = in_set && !any_btn && to_tick && (to_cnt == TO_W'(TIMEOUT_TICKS - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      sh_hour      <= '0;
      sh_min       <= '0;
      load         <= 1'b0;
      ld_hour_ten  <= '0;
      ld_hour_unit <= '0;
      ld_min_ten   <= '0;
      ld_min_unit  <= '0;
      editing      <= EDIT_NONE;
      blink        <= 1'b0;
    end else begin
      load <= 1'b0;
      if (blink_tick) blink <= ~blink;

      case (state)
        RUN: begin
          if (btn_mode) begin
            state        <= SET_HOUR;
            sh_hour.ten  <= cur_hour_ten;
            sh_hour.unit <= cur_hour_unit;
            sh_min.ten   <= cur_min_ten;
            sh_min.unit  <= cur_min_unit;
            editing      <= EDIT_HOUR;
            blink        <= 1'b0;
          end
        end
        SET_HOUR: begin
          // Mode has priority: a coincident inc is dropped.
          if (btn_mode) begin
            state   <= SET_MIN;
            editing <= EDIT_MIN;
            blink   <= 1'b0;
          end else if (btn_inc) begin
            sh_hour <= hour_inc(sh_hour);
            blink   <= 1'b0;
          end else if (timeout) begin
            state   <= RUN;
            editing <= EDIT_NONE;
            blink   <= 1'b0;
          end
        end
        SET_MIN: begin
          if (btn_mode) begin
            state        <= COMMIT;
            editing      <= EDIT_NONE;
            blink        <= 1'b0;
            load         <= 1'b1;
            ld_hour_ten  <= sh_hour.ten;
            ld_hour_unit <= sh_hour.unit;
            ld_min_ten   <= sh_min.ten;
            ld_min_unit  <= sh_min.unit;
          end else if (btn_inc) begin
            sh_min <= min_inc(sh_min);
            blink  <= 1'b0;
          end else if (timeout) begin
            state   <= RUN;
            editing <= EDIT_NONE;
            blink   <= 1'b0;
          end
        end
        COMMIT: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign ld_sec_clr = load;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl (CLK_DIV=4, BLINK_DIV=2, TIMEOUT_TICKS=3);
// tick/load events and editing/blink snapshots are queued by cycle number.
module tb_clock_set_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] cur_hour_ten;
  logic [3:0] cur_hour_unit;
  logic [2:0] cur_min_ten;
  logic [3:0] cur_min_unit;
  logic       tick_en;
  logic       load;
  logic [1:0] ld_hour_ten;
  logic [3:0] ld_hour_unit;
  logic [2:0] ld_min_ten;
  logic [3:0] ld_min_unit;
  logic       ld_sec_clr;
  logic [1:0] editing;
  logic       blink;

  clock_set_ctrl #(
    .CLK_DIV       (4),
    .BLINK_DIV     (2),
    .TIMEOUT_TICKS (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .cur_hour_ten  (cur_hour_ten),
    .cur_hour_unit (cur_hour_unit),
    .cur_min_ten   (cur_min_ten),
    .cur_min_unit  (cur_min_unit),
    .tick_en       (tick_en),
    .load          (load),
    .ld_hour_ten   (ld_hour_ten),
    .ld_hour_unit  (ld_hour_unit),
    .ld_min_ten    (ld_min_ten),
    .ld_min_unit   (ld_min_unit),
    .ld_sec_clr    (ld_sec_clr),
    .editing       (editing),
    .blink         (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_load;
    logic [12:0] ld;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [1:0] editing;
    logic       blink;
  } snap_t;

  ev_t   ev_q[$];
  snap_t snap_q[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  // Cycle 1 is the cycle in which reset is released.
  int cyc = 1;
  always @(posedge clk) begin
    if (!reset) cyc <= 1;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_tick(input int c);
    ev_t e;
    e.cyc = c; e.is_load = 1'b0; e.ld = '0;
    ev_q.push_back(e);
  endtask

  task automatic push_load(input int c, input int hh, input int mm);
    ev_t e;
    e.cyc     = c;
    e.is_load = 1'b1;
    e.ld      = {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10)};
    ev_q.push_back(e);
  endtask

  task automatic push_snap(input int c, input logic [1:0] ed, input logic bl);
    snap_t s;
    s.cyc = c; s.editing = ed; s.blink = bl;
    snap_q.push_back(s);
  endtask

  // Monitor: pops whenever the DUT presents tick_en/load, and checks queued
  // editing/blink snapshots on their cycle.
  ev_t         mon_e;
  snap_t       mon_s;
  logic [12:0] mon_ld;
  always @(negedge clk) begin
    if (reset) begin
      mon_ld = {ld_hour_ten, ld_hour_unit, ld_min_ten, ld_min_unit};
      if (tick_en || load || ld_sec_clr) begin
        n_vec++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: cyc=%0d tick_en=%b load=%b sec_clr=%b, expected none",
                   cyc, tick_en, load, ld_sec_clr);
        end else begin
          mon_e = ev_q.pop_front();
          if (mon_e.cyc != cyc || load !== mon_e.is_load || tick_en !== !mon_e.is_load ||
              ld_sec_clr !== mon_e.is_load || (mon_e.is_load && mon_ld !== mon_e.ld)) begin
            n_fail++;
            $display("FAIL event: got cyc=%0d tick_en=%b load=%b sec_clr=%b ld=%h, expected cyc=%0d load=%b ld=%h",
                     cyc, tick_en, load, ld_sec_clr, mon_ld, mon_e.cyc, mon_e.is_load, mon_e.ld);
          end
        end
      end
      if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
        mon_s = snap_q.pop_front();
        n_vec++;
        if (editing !== mon_s.editing || blink !== mon_s.blink) begin
          n_fail++;
          $display("FAIL snap@%0d: got editing=%b blink=%b, expected editing=%b blink=%b",
                   cyc, editing, blink, mon_s.editing, mon_s.blink);
        end
      end
    end
  end

  task automatic at_cycle(input int k);
    for (int i = 0; i < 200 && cyc != k; i++) @(negedge clk);
    check("sync_cycle", cyc, k);
  endtask

  task automatic press(input int k, input logic m, input logic i);
    at_cycle(k);
    btn_mode = m;
    btn_inc  = i;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick_en"}, tick_en, 0);
    check({tag, "_load"}, load, 0);
    check({tag, "_sec_clr"}, ld_sec_clr, 0);
    check({tag, "_editing"}, editing, 0);
    check({tag, "_blink"}, blink, 0);
    check({tag, "_ld"}, {ld_hour_ten, ld_hour_unit, ld_min_ten, ld_min_unit}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cur_hour_ten = 2'd2; cur_hour_unit = 4'd1;
    cur_min_ten  = 3'd5; cur_min_unit  = 4'd8;

    // Idle ticks, 21:58 -> 00:00 edit, simultaneous buttons, out-of-range capture.
    push_tick(4); push_tick(8); push_tick(12);
    push_snap(14, 2'b01, 1'b0);
    push_snap(17, 2'b01, 1'b0);
    push_snap(18, 2'b01, 1'b0);
    push_snap(19, 2'b01, 1'b1);
    push_snap(20, 2'b10, 1'b0);
    push_load(23, 0, 0);
    push_snap(23, 2'b00, 1'b0);
    push_tick(27);
    push_snap(29, 2'b01, 1'b0);
    push_snap(30, 2'b10, 1'b0);
    push_load(32, 9, 31);
    push_snap(32, 2'b00, 1'b0);
    push_tick(36);
    push_snap(40, 2'b10, 1'b0);
    push_load(43, 0, 1);
    push_tick(47);
    push_snap(50, 2'b10, 1'b0);

    @(negedge clk);
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    press(13, 1'b1, 1'b0);
    press(14, 1'b0, 1'b1);
    press(15, 1'b0, 1'b1);
    press(16, 1'b0, 1'b1);
    press(19, 1'b1, 1'b0);
    press(20, 1'b0, 1'b1);
    press(21, 1'b0, 1'b1);
    press(22, 1'b1, 1'b0);

    cur_hour_ten = 2'd0; cur_hour_unit = 4'd9;
    cur_min_ten  = 3'd3; cur_min_unit  = 4'd0;
    press(28, 1'b1, 1'b0);
    press(29, 1'b1, 1'b1);
    press(30, 1'b0, 1'b1);
    press(31, 1'b1, 1'b0);

    cur_hour_ten = 2'd2; cur_hour_unit = 4'd5;
    cur_min_ten  = 3'd6; cur_min_unit  = 4'd7;
    press(37, 1'b1, 1'b0);
    press(38, 1'b0, 1'b1);
    press(39, 1'b1, 1'b0);
    press(40, 1'b0, 1'b1);
    press(41, 1'b0, 1'b1);
    press(42, 1'b1, 1'b0);

    // Reset dropped while editing minutes: no load, everything back to zero.
    press(48, 1'b1, 1'b0);
    press(49, 1'b1, 1'b0);
    at_cycle(51);
    reset = 1'b0;
    #1;
    check_all_zero("midedit_reset");
    check("pending_before_reset", ev_q.size() + snap_q.size(), 0);

    push_tick(4); push_tick(8);
`ifdef SET_TIMEOUT_EN
    push_snap(10, 2'b01, 1'b0);
    push_snap(12, 2'b01, 1'b1);
    push_snap(21, 2'b01, 1'b1);
    push_snap(22, 2'b00, 1'b0);
    push_tick(25); push_tick(29);
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;

`ifdef SET_TIMEOUT_EN
    press(9, 1'b1, 1'b0);
    at_cycle(30);
`else
    at_cycle(10);
`endif

    check("events_left", ev_q.size(), 0);
    check("snaps_left", snap_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
